// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types for the cache-to-memory arbiter.
//   arb_state_t : which cache (if any) currently owns the memory port
//   grant_t     : which cache won the most recent grant (round-robin history)
//   mem_op_t    : kind of line transaction held in the command latch
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } mem_op_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
// Shares one physical-memory line port between the icache and the dcache.
// Fair two-way round-robin pick, one line transaction in flight at a time.
// The winner's command is captured on the grant edge and the memory port is
// driven only from that capture until mem_resp; the response is then routed
// to the owning cache only.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   i_pmem_read/address            icache line-read request
//   i_pmem_rdata/resp              line data and completion pulse to icache
//   d_pmem_read/write/address/     dcache line-read / writeback request
//   d_pmem_wdata
//   d_pmem_rdata/resp              line data and completion pulse to dcache
//   mem_read/write/address/wdata   command to physical memory
//   mem_rdata/resp                 data and completion from physical memory
// -----------------------------------------------------------------------------
module cache_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        state_q, state_d;
    grant_t            lastGrant_q, lastGrant_d;
    mem_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    logic iReq;
    logic dReq;
    logic pickD;

    assign iReq = i_pmem_read;
    assign dReq = d_pmem_read | d_pmem_write;

    // State register, round-robin history and command latch. Reset forces
    // IDLE immediately, which in turn forces every output to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGrant_q <= GRANT_I;
            op_q        <= OP_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Next-state and grant pick. On a tie the cache that did not win last
    // time gets the port, so continuous contention alternates D,I,D,I...
    // A dcache write beats a simultaneous dcache read.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pickD       = 1'b0;
        case (state_q)
            IDLE: begin
                pickD = dReq && (!iReq || (lastGrant_q == GRANT_I));
                if (pickD) begin
                    state_d     = SERVE_D;
                    lastGrant_d = GRANT_D;
                    op_d        = d_pmem_write ? OP_WRITE : OP_READ;
                    addr_d      = d_pmem_address;
                    wdata_d     = d_pmem_wdata;
                end else if (iReq) begin
                    state_d     = SERVE_I;
                    lastGrant_d = GRANT_I;
                    op_d        = OP_READ;
                    addr_d      = i_pmem_address;
                    wdata_d     = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs. The memory command comes only from the latch; completion and
    // line data are passed through combinationally to the owner alone.
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = '0;
        mem_wdata    = '0;
        i_pmem_resp  = 1'b0;
        i_pmem_rdata = '0;
        d_pmem_resp  = 1'b0;
        d_pmem_rdata = '0;
        case (state_q)
            SERVE_I, SERVE_D: begin
                mem_read    = (op_q == OP_READ);
                mem_write   = (op_q == OP_WRITE);
                mem_address = addr_q;
                mem_wdata   = wdata_q;
                if (state_q == SERVE_I) begin
                    i_pmem_resp  = mem_resp;
                    i_pmem_rdata = mem_rdata;
                end else begin
                    d_pmem_resp  = mem_resp;
                    d_pmem_rdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
// Directed scenarios with literal expectations, followed by a randomized
// phase. A transaction-level model of the arbiter tracks who owns the memory
// port and what command was captured; its predicted outputs are compared
// against the DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_pmem_read = 1'b0;
    logic [ADDR_W-1:0] i_pmem_address = '0;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read = 1'b0;
    logic              d_pmem_write = 1'b0;
    logic [ADDR_W-1:0] d_pmem_address = '0;
    logic [LINE_W-1:0] d_pmem_wdata = '0;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata = '0;
    logic              mem_resp = 1'b0;

    int checks = 0;
    int errors = 0;

    localparam logic [LINE_W-1:0] LINE_A5 = {32{8'hA5}};
    localparam logic [LINE_W-1:0] LINE_5A = {32{8'h5A}};

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                               input logic [LINE_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: owner is 0 (nobody), 1 (icache) or 2 (dcache).
    // ---------------------------------------------------------------------
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } txn_t;

    int   owner = 0;
    int   lastWinner = 1;
    txn_t cur = '0;
    int   pickWho;
    txn_t pickTxn;

    // Who would win if the port were free right now: a lone requester wins,
    // a tie goes to whoever did not win last.
    always_comb begin
        pickWho = 0;
        pickTxn = '0;
        if (i_pmem_read && (d_pmem_read || d_pmem_write)) begin
            pickWho = (lastWinner == 1) ? 2 : 1;
        end else if (i_pmem_read) begin
            pickWho = 1;
        end else if (d_pmem_read || d_pmem_write) begin
            pickWho = 2;
        end
        if (pickWho == 1) begin
            pickTxn = '{write: 1'b0, addr: i_pmem_address, wdata: '0};
        end else if (pickWho == 2) begin
            pickTxn = '{write: d_pmem_write, addr: d_pmem_address, wdata: d_pmem_wdata};
        end
    end

    // Ownership changes: a response frees the port, a free port is handed
    // to the pick; reset abandons whatever was in flight.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= 0;
            lastWinner <= 1;
            cur        <= '0;
        end else if (owner != 0) begin
            if (mem_resp) owner <= 0;
        end else if (pickWho != 0) begin
            owner      <= pickWho;
            lastWinner <= pickWho;
            cur        <= pickTxn;
        end
    end

    logic              expRead, expWrite, expIResp, expDResp;
    logic [ADDR_W-1:0] expAddr;
    logic [LINE_W-1:0] expWdata, expIRdata, expDRdata;

    // Predicted outputs from the current owner and captured command.
    always_comb begin
        expRead   = (owner != 0) && !cur.write;
        expWrite  = (owner != 0) && cur.write;
        expAddr   = (owner != 0) ? cur.addr : '0;
        expWdata  = (owner != 0) ? cur.wdata : '0;
        expIResp  = (owner == 1) && mem_resp;
        expDResp  = (owner == 2) && mem_resp;
        expIRdata = (owner == 1) ? mem_rdata : '0;
        expDRdata = (owner == 2) ? mem_rdata : '0;
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        checkOutput("mem_read", mem_read, expRead);
        checkOutput("mem_write", mem_write, expWrite);
        checkOutput("mem_address", mem_address, expAddr);
        checkOutput("mem_wdata", mem_wdata, expWdata);
        checkOutput("i_pmem_resp", i_pmem_resp, expIResp);
        checkOutput("d_pmem_resp", d_pmem_resp, expDResp);
        checkOutput("i_pmem_rdata", i_pmem_rdata, expIRdata);
        checkOutput("d_pmem_rdata", d_pmem_rdata, expDRdata);
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic iRead, input logic [ADDR_W-1:0] iAddr,
                                 input logic dRead, input logic dWrite,
                                 input logic [ADDR_W-1:0] dAddr,
                                 input logic [LINE_W-1:0] dWdata);
        i_pmem_read    = iRead;
        i_pmem_address = iAddr;
        d_pmem_read    = dRead;
        d_pmem_write   = dWrite;
        d_pmem_address = dAddr;
        d_pmem_wdata   = dWdata;
    endtask

    task automatic waitCommand(input string name);
        int n = 0;
        while (!(mem_read || mem_write) && n < 50) begin
            tick();
            n++;
        end
        checkOutput(name, mem_read | mem_write, 1);
    endtask

    function automatic logic [LINE_W-1:0] randLine();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Random caches and a memory with 0..4 cycles of latency that sometimes
    // pulses mem_resp while nothing is outstanding.
    task automatic runRandom(input int cycles);
        logic iDone, dDone, respNow;
        int   lat = 0;
        int   r;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            iDone   = i_pmem_resp;
            dDone   = d_pmem_resp;
            respNow = mem_resp;
            tick();
            if (i_pmem_read && iDone) begin
                i_pmem_read = 1'b0;
            end else if (!i_pmem_read) begin
                if ($urandom_range(2) == 0) begin
                    i_pmem_read    = 1'b1;
                    i_pmem_address = $urandom;
                end
            end else begin
                if ($urandom_range(19) == 0) i_pmem_address = $urandom;
                if ($urandom_range(39) == 0) i_pmem_read = 1'b0;
            end
            if ((d_pmem_read || d_pmem_write) && dDone) begin
                d_pmem_read  = 1'b0;
                d_pmem_write = 1'b0;
            end else if (!(d_pmem_read || d_pmem_write)) begin
                if ($urandom_range(2) == 0) begin
                    r              = $urandom_range(15);
                    d_pmem_write   = (r < 7);
                    d_pmem_read    = (r >= 7) || (r == 0);
                    d_pmem_address = $urandom;
                    d_pmem_wdata   = randLine();
                end
            end else begin
                if ($urandom_range(19) == 0) d_pmem_address = $urandom;
                if ($urandom_range(19) == 0) d_pmem_wdata = randLine();
                if ($urandom_range(39) == 0) begin
                    d_pmem_read  = 1'b0;
                    d_pmem_write = 1'b0;
                end
            end
            mem_rdata = randLine();
            if (respNow) begin
                mem_resp = 1'b0;
            end else if (mem_read || mem_write) begin
                if (lat == 0) mem_resp = 1'b1;
                else lat--;
            end else begin
                lat      = $urandom_range(4);
                mem_resp = ($urandom_range(15) == 0);
            end
        end
    endtask

    // ---------------------------------------------------------------------
    // Directed scenarios, then random traffic, then the summary.
    // ---------------------------------------------------------------------
    initial begin
        logic [5:0] order;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_mem_read", mem_read, 0);
        checkOutput("reset_mem_address", mem_address, 0);
        checkOutput("reset_i_resp", i_pmem_resp, 0);

        // Lone icache read, memory answers in the fourth command cycle.
        applyStimulus(1, 32'h1000, 0, 0, '0, '0);
        tick();
        checkOutput("t1_mem_read", mem_read, 1);
        checkOutput("t1_mem_write", mem_write, 0);
        checkOutput("t1_mem_address", mem_address, 32'h1000);
        repeat (3) tick();
        mem_resp  = 1'b1;
        mem_rdata = LINE_A5;
        #1;
        checkOutput("t1_i_resp", i_pmem_resp, 1);
        checkOutput("t1_i_rdata", i_pmem_rdata, LINE_A5);
        checkOutput("t1_d_resp", d_pmem_resp, 0);
        checkOutput("t1_d_rdata", d_pmem_rdata, 0);
        tick();
        mem_resp = 1'b0;
        applyStimulus(0, '0, 0, 0, '0, '0);
        #1;
        checkOutput("t1_i_resp_end", i_pmem_resp, 0);
        checkOutput("t1_idle", mem_read, 0);

        // Fresh reset, simultaneous requests: dcache wins the first tie.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1, 32'h1000, 0, 1, 32'h2000, LINE_5A);
        tick();
        checkOutput("t2_mem_write", mem_write, 1);
        checkOutput("t2_mem_read", mem_read, 0);
        checkOutput("t2_mem_address", mem_address, 32'h2000);
        checkOutput("t2_mem_wdata", mem_wdata, LINE_5A);
        mem_resp = 1'b1;
        #1;
        checkOutput("t2_d_resp", d_pmem_resp, 1);
        checkOutput("t2_i_resp", i_pmem_resp, 0);
        tick();
        mem_resp = 1'b0;
        applyStimulus(1, 32'h1000, 0, 0, '0, '0);
        #1;
        checkOutput("t2_gap", mem_read | mem_write, 0);
        tick();
        checkOutput("t2_i_mem_read", mem_read, 1);
        checkOutput("t2_i_mem_address", mem_address, 32'h1000);
        mem_resp = 1'b1;
        #1;
        checkOutput("t2_i_resp", i_pmem_resp, 1);
        tick();
        mem_resp = 1'b0;
        applyStimulus(0, '0, 0, 0, '0, '0);

        // Continuous contention for six transactions: D,I,D,I,D,I.
        applyStimulus(1, 32'h1000, 0, 1, 32'h2000, LINE_5A);
        order = '0;
        for (int k = 0; k < 6; k++) begin
            waitCommand("t3_cmd");
            order    = {order[4:0], mem_write};
            mem_resp = 1'b1;
            tick();
            mem_resp = 1'b0;
            #1;
            checkOutput("t3_gap", mem_read | mem_write, 0);
        end
        checkOutput("t3_order", order, 6'b101010);
        applyStimulus(0, '0, 0, 0, '0, '0);
        tick();

        // Address change and request drop during SERVE_I have no effect.
        applyStimulus(1, 32'h1000, 0, 0, '0, '0);
        tick();
        checkOutput("t4_mem_address", mem_address, 32'h1000);
        applyStimulus(0, 32'h3000, 0, 0, '0, '0);
        tick();
        checkOutput("t4_mem_read_held", mem_read, 1);
        checkOutput("t4_mem_address_held", mem_address, 32'h1000);
        tick();
        mem_resp = 1'b1;
        #1;
        checkOutput("t4_i_resp", i_pmem_resp, 1);
        tick();
        mem_resp = 1'b0;
        #1;
        checkOutput("t4_i_resp_once", i_pmem_resp, 0);

        // Reset between clock edges during SERVE_D, then a lone icache read.
        applyStimulus(0, '0, 1, 0, 32'h4000, '0);
        tick();
        checkOutput("t5_mem_read", mem_read, 1);
        checkOutput("t5_mem_address", mem_address, 32'h4000);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_rst_mem_read", mem_read, 0);
        checkOutput("t5_rst_mem_address", mem_address, 0);
        applyStimulus(0, '0, 0, 0, '0, '0);
        tick();
        rst = 1'b0;
        applyStimulus(1, 32'h1000, 0, 0, '0, '0);
        tick();
        checkOutput("t5_i_mem_read", mem_read, 1);
        checkOutput("t5_i_mem_address", mem_address, 32'h1000);
        mem_resp = 1'b1;
        #1;
        checkOutput("t5_i_resp", i_pmem_resp, 1);
        tick();
        mem_resp = 1'b0;
        applyStimulus(0, '0, 0, 0, '0, '0);

        // Stray mem_resp while idle is not forwarded.
        tick();
        mem_resp  = 1'b1;
        mem_rdata = LINE_A5;
        #1;
        checkOutput("t6_i_resp", i_pmem_resp, 0);
        checkOutput("t6_d_resp", d_pmem_resp, 0);
        checkOutput("t6_i_rdata", i_pmem_rdata, 0);
        tick();
        mem_resp = 1'b0;
        #1;
        checkOutput("t6_still_idle", mem_read | mem_write, 0);

        runRandom(3000);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
